pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Multicycle fetch/execute controller that owns the program counter register's write port. It fetches each instruction from instruction memory over a req/ack handshake and latches it into the instruction register. It then steps the core through DECODE, EXECUTE and WRITEBACK, and in WRITEBACK commits either PC+1 or a branch target. It sits between the program counter register, instruction memory and the ALU/regfile control.

Parameters:
ADDR_W, 16, PC / memory address width
DATA_W, 16, instruction width
MEM_TIMEOUT, 15, max FETCH cycles without mem_ack before FAULT (1..255)
HALT_OPCODE, 4'hF, value of instr[15:12] that halts the core

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  level; enables instruction sequencing
halt_req  in  1  external halt request
pc_cur  in  ADDR_W  current PC value from the program counter register
mem_ack  in  1  instruction memory data valid
instr  in  DATA_W  instruction memory read data
branch_taken  in  1  from ALU flags, sampled in WRITEBACK
branch_target  in  ADDR_W  sampled in WRITEBACK
mem_req  out  1  instruction fetch request
mem_addr  out  ADDR_W  fetch address (= pc_cur)
ir  out  DATA_W  instruction register
ir_valid  out  1  ir holds a fetched instruction
exec_en  out  1  ALU execute strobe
wb_en  out  1  register-file write strobe
pc_write  out  1  PC load strobe
pc_data  out  ADDR_W  PC load value
state  out  3  current FSM state (debug)
fault  out  1  sticky fetch-timeout fault

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5, FAULT=6. Value 7 is illegal; it recovers to IDLE on the next edge.
- Reset (rst=0, async): state=IDLE, ir=0, ir_valid=0, fault=0, timeout counter=0.
- All strobes drop within the reset assertion, with no clock required. This includes reset asserted mid-FETCH: mem_req drops immediately.
- mem_req, exec_en, wb_en and pc_write are Moore outputs decoded from state only. mem_addr = pc_cur at all times.
- IDLE: if halt_req=1 go to HALTED (halt wins over run). Else if run=1 go to FETCH. Else stay in IDLE.
- FETCH: mem_req=1. The timeout counter increments each cycle without an ack.
  - On mem_ack=1: ir<=instr, ir_valid<=1, counter<=0, go to DECODE.
  - If the counter reaches MEM_TIMEOUT with no ack: fault<=1, go to FAULT.
  - An ack arriving in the same cycle the counter hits MEM_TIMEOUT wins. No fault is raised.
- DECODE: one cycle. If ir[15:12]==HALT_OPCODE go to HALTED with no PC update; else go to EXECUTE.
- EXECUTE: exec_en=1 for exactly one cycle, then go to WRITEBACK.
- WRITEBACK: wb_en=1 and pc_write=1 for one cycle.
  - pc_data = branch_taken ? branch_target : pc_cur+1, computed modulo 2^ADDR_W, so 16'hFFFF+1 = 16'h0000.
  - Next state, in priority order: halt_req=1 goes to HALTED; run=0 goes to IDLE; otherwise FETCH.
- pc_data outside WRITEBACK = pc_cur+1. It is a don't-care for consumers because pc_write=0.
- HALTED: all strobes 0, ir_valid cleared. Leaves to IDLE only when run=0 and halt_req=0.
- FAULT: fault=1, all strobes 0. Exit only via rst.
- mem_ack outside FETCH is ignored; ir is unchanged.
- run and halt_req are ignored except in IDLE, WRITEBACK and HALTED. A started instruction always completes WRITEBACK.
- Latency: with zero-wait memory (ack in the first FETCH cycle) an instruction takes 4 cycles, FETCH→DECODE→EXECUTE→WRITEBACK. Each memory wait cycle adds 1.

Test Plan:
- Release rst, pc_cur=16'h0010, run=1, mem_ack tied 1, instr=16'h1234, no branch → state sequence 0,1,2,3,4,1; pc_write pulses once per 4 cycles with pc_data=16'h0011; ir=16'h1234.
- pc_cur=16'hFFFF, branch_taken=0 → WRITEBACK pc_data=16'h0000. Then branch_taken=1, branch_target=16'h00A0 → pc_data=16'h00A0.
- mem_ack held 0 in FETCH → fault=1 and state=6 after 15 cycles, strobes 0. Repeat with ack on the 15th cycle → DECODE, no fault.
- instr=16'hF000 → DECODE goes to HALTED with no pc_write. Drop run and keep halt_req=0 → IDLE. Raise run → FETCH.
- halt_req=1 asserted during EXECUTE → WRITEBACK still pulses pc_write, then state=HALTED. run=0 during WRITEBACK → IDLE.
- Assert rst mid-FETCH with mem_req=1 → mem_req=0 and state=0 before the next clock edge; ir=0, ir_valid=0, fault=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-fetch bus between the fetch/execute sequencer and instruction
// memory.
//   mem_req  : fetch request (sequencer -> memory)
//   mem_addr : fetch address (sequencer -> memory)
//   mem_ack  : read data valid (memory -> sequencer)
//   instr    : read data (memory -> sequencer)
// The master modport is the sequencer side; the slave modport is the memory side.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] instr;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  instr
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output instr
   );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Multicycle fetch/execute controller that owns the write port of the program
// counter register. Each instruction is fetched over a req/ack handshake,
// latched into the instruction register, and then stepped through
// DECODE, EXECUTE and WRITEBACK. WRITEBACK commits either PC+1 or a branch
// target.
//
// Ports
//   clk           : system clock, rising edge
//   rst           : asynchronous, active-low reset
//   run           : level; enables instruction sequencing
//   halt_req      : external halt request
//   pc_cur        : current PC from the program counter register
//   mem           : instruction-fetch bus (master side)
//   branch_taken  : ALU branch flag, sampled in WRITEBACK
//   branch_target : branch destination, sampled in WRITEBACK
//   ir / ir_valid : instruction register and its valid flag
//   exec_en       : ALU execute strobe
//   wb_en         : register-file write strobe
//   pc_write      : PC load strobe
//   pc_data       : PC load value
//   state         : current FSM state (debug)
//   fault         : sticky fetch-timeout fault
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int          ADDR_W      = 16,
   parameter int          DATA_W      = 16,
   parameter int          MEM_TIMEOUT = 15,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              halt_req,
   input  logic [ADDR_W-1:0] pc_cur,
   pc_sequencer_if.master    mem,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [DATA_W-1:0] ir,
   output logic              ir_valid,
   output logic              exec_en,
   output logic              wb_en,
   output logic              pc_write,
   output logic [ADDR_W-1:0] pc_data,
   output logic [2:0]        state,
   output logic              fault
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      WRITEBACK = 3'd4,
      HALTED    = 3'd5,
      FAULT     = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        tmo_q, tmo_d;
   logic [7:0]        tmo_inc;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;
   logic              fault_q, fault_d;
   logic [ADDR_W-1:0] pc_plus1;

   assign tmo_inc  = tmo_q + 8'd1;
   assign pc_plus1 = pc_cur + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         tmo_q      <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         fault_q    <= fault_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      fault_d    = fault_q;

      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (halt_req)
               state_d = HALTED;
            else if (run)
               state_d = FETCH;
         end

         FETCH: begin
            // tmo_q counts FETCH cycles already spent without an ack, so the
            // MEM_TIMEOUT-th unacknowledged cycle faults; an ack in that same
            // cycle takes priority.
            if (mem.mem_ack) begin
               ir_d       = mem.instr;
               ir_valid_d = 1'b1;
               tmo_d      = '0;
               state_d    = DECODE;
            end else if (tmo_inc == 8'(MEM_TIMEOUT)) begin
               fault_d = 1'b1;
               tmo_d   = '0;
               state_d = FAULT;
            end else begin
               tmo_d = tmo_inc;
            end
         end

         DECODE: begin
            if (ir_q[DATA_W-1 -: 4] == HALT_OPCODE)
               state_d = HALTED;
            else
               state_d = EXECUTE;
         end

         EXECUTE: state_d = WRITEBACK;

         WRITEBACK: begin
            if (halt_req)
               state_d = HALTED;
            else if (!run)
               state_d = IDLE;
            else
               state_d = FETCH;
         end

         HALTED: begin
            if (!run && !halt_req)
               state_d = IDLE;
         end

         FAULT: fault_d = 1'b1;

         default: state_d = IDLE;
      endcase

      // ir_valid is already low in the first HALTED cycle.
      if (state_d == HALTED)
         ir_valid_d = 1'b0;
   end

   // Moore strobes decoded from the registered state only, so they fall as
   // soon as the asynchronous reset forces IDLE.
   assign mem.mem_req  = (state_q == FETCH);
   assign mem.mem_addr = pc_cur;
   assign exec_en      = (state_q == EXECUTE);
   assign wb_en        = (state_q == WRITEBACK);
   assign pc_write     = (state_q == WRITEBACK);
   assign pc_data      = ((state_q == WRITEBACK) && branch_taken) ? branch_target : pc_plus1;

   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign state    = state_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int TMO = 15;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_DEC   = 3'd2;
   localparam logic [2:0] S_EXE   = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;
   localparam logic [2:0] S_FAULT = 3'd6;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          halt_req;
   logic [AW-1:0] pc_cur;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic [DW-1:0] ir;
   logic          ir_valid;
   logic          exec_en;
   logic          wb_en;
   logic          pc_write;
   logic [AW-1:0] pc_data;
   logic [2:0]    state;
   logic          fault;

   int tests = 0;
   int fails = 0;

   // reference copy of the instruction register
   logic [DW-1:0] m_ir  = '0;
   logic          m_irv = 1'b0;

   pc_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

   pc_sequencer #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .MEM_TIMEOUT(TMO),
      .HALT_OPCODE(4'hF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .run(run),
      .halt_req(halt_req),
      .pc_cur(pc_cur),
      .mem(mem_if.master),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .ir(ir),
      .ir_valid(ir_valid),
      .exec_en(exec_en),
      .wb_en(wb_en),
      .pc_write(pc_write),
      .pc_data(pc_data),
      .state(state),
      .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs for this cycle are already driven (just after a falling edge).
   // Check every output against the expected state, then advance one cycle.
   task automatic step(input logic [2:0] es);
      logic [AW-1:0] exp_pd;
      #1;
      if (es == S_HALT) m_irv = 1'b0;
      exp_pd = (es == S_WB && branch_taken) ? branch_target : AW'(32'(pc_cur) + 1);
      chk("state",    32'(state),           32'(es));
      chk("mem_req",  32'(mem_if.mem_req), 32'(es == S_FETCH));
      chk("exec_en",  32'(exec_en),         32'(es == S_EXE));
      chk("wb_en",    32'(wb_en),           32'(es == S_WB));
      chk("pc_write", 32'(pc_write),        32'(es == S_WB));
      chk("mem_addr", 32'(mem_if.mem_addr), 32'(pc_cur));
      chk("pc_data",  32'(pc_data),         32'(exp_pd));
      chk("fault",    32'(fault),           32'(es == S_FAULT));
      chk("ir",       32'(ir),              32'(m_ir));
      chk("ir_valid", 32'(ir_valid),        32'(m_irv));
      if (es == S_FETCH && mem_if.mem_ack) begin
         m_ir  = mem_if.instr;
         m_irv = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      m_ir  = '0;
      m_irv = 1'b0;
      chk("rst_state",    32'(state),           32'(S_IDLE));
      chk("rst_mem_req",  32'(mem_if.mem_req), 32'd0);
      chk("rst_pc_write", 32'(pc_write),        32'd0);
      chk("rst_exec_en",  32'(exec_en),         32'd0);
      chk("rst_wb_en",    32'(wb_en),           32'd0);
      chk("rst_ir",       32'(ir),              32'd0);
      chk("rst_ir_valid", 32'(ir_valid),        32'd0);
      chk("rst_fault",    32'(fault),           32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One cycle in IDLE or HALTED with the given run/halt_req levels.
   task automatic ctl(input logic [2:0] cur, input logic r, input logic h, output logic [2:0] nxt);
      run              = r;
      halt_req         = h;
      mem_if.mem_ack   = 1'($urandom_range(0, 1));
      mem_if.instr     = DW'($urandom);
      step(cur);
      if (cur == S_IDLE)
         nxt = h ? S_HALT : (r ? S_FETCH : S_IDLE);
      else
         nxt = (!r && !h) ? S_IDLE : S_HALT;
   endtask

   task automatic to_fetch(input logic [2:0] cur, output logic [2:0] nxt);
      logic [2:0] s;
      s = cur;
      for (int i = 0; i < 4 && s != S_FETCH; i++) begin
         if (s == S_HALT) ctl(s, 1'b0, 1'b0, s);
         else             ctl(s, 1'b1, 1'b0, s);
      end
      nxt = s;
   endtask

   // One instruction starting in its first FETCH cycle. The acknowledge comes
   // after 'waits' empty cycles; run/halt_req/mem_ack are noise outside the
   // points where they matter. The bench's PC register loads the committed value.
   task automatic do_instr(input logic [DW-1:0] ins, input int waits, input logic br,
                           input logic [AW-1:0] tgt, input logic end_run, input logic end_halt,
                           output logic [2:0] nxt);
      logic [AW-1:0] exp_pc;
      for (int k = 0; k <= waits; k++) begin
         mem_if.mem_ack = (k == waits);
         mem_if.instr   = (k == waits) ? ins : DW'($urandom);
         run            = 1'($urandom_range(0, 1));
         halt_req       = 1'($urandom_range(0, 1));
         step(S_FETCH);
      end
      mem_if.mem_ack = 1'($urandom_range(0, 1));
      mem_if.instr   = DW'($urandom);
      run            = 1'($urandom_range(0, 1));
      halt_req       = 1'($urandom_range(0, 1));
      step(S_DEC);
      if (ins[DW-1 -: 4] == 4'hF) begin
         nxt = S_HALT;
         return;
      end
      mem_if.mem_ack = 1'($urandom_range(0, 1));
      run            = 1'($urandom_range(0, 1));
      halt_req       = 1'($urandom_range(0, 1));
      step(S_EXE);
      mem_if.mem_ack = 1'($urandom_range(0, 1));
      run            = end_run;
      halt_req       = end_halt;
      branch_taken   = br;
      branch_target  = tgt;
      exp_pc         = br ? tgt : AW'(32'(pc_cur) + 1);
      step(S_WB);
      pc_cur         = exp_pc;
      branch_taken   = 1'($urandom_range(0, 1));
      branch_target  = AW'($urandom);
      nxt = end_halt ? S_HALT : (end_run ? S_FETCH : S_IDLE);
   endtask

   initial begin
      logic [2:0]    s;
      logic [DW-1:0] ins;
      rst            = 1'b0;
      run            = 1'b0;
      halt_req       = 1'b0;
      pc_cur         = '0;
      branch_taken   = 1'b0;
      branch_target  = '0;
      mem_if.mem_ack = 1'b0;
      mem_if.instr   = '0;

      do_reset();
      s = S_IDLE;
      ctl(s, 1'b0, 1'b0, s);

      // basic zero-wait sequencing and PC+1
      pc_cur = 16'h0010;
      ctl(s, 1'b1, 1'b0, s);
      do_instr(16'h1234, 0, 1'b0, 16'h0000, 1'b1, 1'b0, s);
      chk("pc_after_1", 32'(pc_cur), 32'h0011);
      do_instr(16'h1234, 0, 1'b0, 16'h0000, 1'b1, 1'b0, s);

      // PC wrap and branch
      pc_cur = 16'hFFFF;
      do_instr(16'h2222, 0, 1'b0, 16'h5555, 1'b1, 1'b0, s);
      chk("pc_wrap", 32'(pc_cur), 32'h0000);
      do_instr(16'h3333, 1, 1'b1, 16'h00A0, 1'b1, 1'b0, s);
      chk("pc_branch", 32'(pc_cur), 32'h00A0);

      // halt opcode, then HALTED exit rules
      do_instr(16'hF000, 1, 1'b0, 16'h0000, 1'b1, 1'b0, s);
      ctl(s, 1'b1, 1'b0, s);
      ctl(s, 1'b0, 1'b1, s);
      ctl(s, 1'b1, 1'b1, s);
      ctl(s, 1'b0, 1'b0, s);
      ctl(s, 1'b1, 1'b0, s);

      // halt at end of an instruction, run dropped at end of another
      do_instr(16'h4567, 2, 1'b0, 16'h0000, 1'b1, 1'b1, s);
      to_fetch(s, s);
      do_instr(16'h5678, 0, 1'b1, 16'h0123, 1'b0, 1'b0, s);
      ctl(s, 1'b1, 1'b1, s);
      to_fetch(s, s);

      // randomized instruction stream
      for (int n = 0; n < 30; n++) begin
         ins = DW'($urandom);
         do_instr(ins, $urandom_range(0, 4), 1'($urandom_range(0, 1)), AW'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0), s);
         to_fetch(s, s);
      end

      // ack on the last allowed FETCH cycle wins over the timeout
      do_instr(16'h6789, TMO - 1, 1'b0, 16'h0000, 1'b1, 1'b0, s);
      chk("no_fault_late_ack", 32'(fault), 32'd0);

      // fetch timeout into FAULT, which ignores run/halt_req
      for (int k = 0; k < TMO; k++) begin
         mem_if.mem_ack = 1'b0;
         run            = 1'($urandom_range(0, 1));
         halt_req       = 1'($urandom_range(0, 1));
         step(S_FETCH);
      end
      for (int k = 0; k < 3; k++) begin
         mem_if.mem_ack = 1'($urandom_range(0, 1));
         run            = 1'($urandom_range(0, 1));
         halt_req       = 1'($urandom_range(0, 1));
         step(S_FAULT);
      end
      do_reset();

      // asynchronous reset in the middle of FETCH
      s = S_IDLE;
      to_fetch(s, s);
      do_instr(16'h0ABC, 0, 1'b0, 16'h0000, 1'b1, 1'b0, s);
      mem_if.mem_ack = 1'b0;
      step(S_FETCH);
      #1;
      chk("midfetch_req_before_rst", 32'(mem_if.mem_req), 32'd1);
      do_reset();
      s = S_IDLE;
      ctl(s, 1'b0, 1'b0, s);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
